// File: rtl/unsigned_ha_array_acc_8x8.sv
// Sequential reducer for four weighted half-adder-array rows into a 17-bit product.
// Optional macro HA_ACC_PERF_EN adds a 16-bit completed-transaction counter port.
module unsigned_ha_array_acc_8x8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] product
`ifdef HA_ACC_PERF_EN
  ,
  output logic [15:0] txn_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  row_idx;
  logic [16:0] acc;
  logic [8:0]  row_t [4];
  logic [6:0]  row_b [4];

  logic [8:0]  sel_t;
  logic [6:0]  sel_b;
  logic [9:0]  row_base;
  logic [16:0] row_val;

  // Handshake flags come straight from the state register, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    sel_t = row_t[0];
    sel_b = row_b[0];
    case (row_idx)
      2'd1:    begin sel_t = row_t[1]; sel_b = row_b[1]; end
      2'd2:    begin sel_t = row_t[2]; sel_b = row_b[2]; end
      2'd3:    begin sel_t = row_t[3]; sel_b = row_b[3]; end
      default: begin sel_t = row_t[0]; sel_b = row_b[0]; end
    endcase
    // Bottom vector sits two bit positions above the top vector.
    row_base = {1'b0, sel_t} + {1'b0, sel_b, 2'b00};
    row_val  = 17'(row_base) << {row_idx, 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= 2'd0;
      acc     <= 17'd0;
      // NOTE: the capture array is only four rows, so it is reset like any
      // other register rather than left undefined like a RAM.
      for (int k = 0; k < 4; k++) begin
        row_t[k] <= 9'd0;
        row_b[k] <= 7'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            row_t[0] <= ha_array_0_t;
            row_t[1] <= ha_array_1_t;
            row_t[2] <= ha_array_2_t;
            row_t[3] <= ha_array_3_t;
            row_b[0] <= ha_array_0_b;
            row_b[1] <= ha_array_1_b;
            row_b[2] <= ha_array_2_b;
            row_b[3] <= ha_array_3_b;
            acc      <= 17'd0;
            row_idx  <= 2'd0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc     <= acc + row_val;
          // Index wraps 3->0 naturally, leaving it at 0 for the next transaction.
          row_idx <= row_idx + 2'd1;
          if (row_idx == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HA_ACC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule
